spi_config_master: RTL and testbench
====================================

Name: spi_config_master

Overview:
- SPI mode-0 initiator that serially loads one complete configuration word into the FM transmitter's SPI configuration shift register.
- In the same transfer it reads back the word that register previously held.
- Sits on the controller or test-harness side, in the system clock domain, and generates spi_clk, spi_csn and spi_mosi.
- The word is sent MSB-first. After exactly DW rising edges of spi_clk, the target register holds tx_data bit-for-bit.

Parameters:
- DW, 42, configuration word width in bits. Equals N+L+D+3+3+1 for N=18, L=12, D=5.
- CLK_DIV, 2, system clock cycles per SPI half-period. Legal range is CLK_DIV >= 2.
- CW, 8, width of the internal half-period counter. Must satisfy 2**CW > CLK_DIV.

Ports:
- clk  input  1  system clock. All logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a transfer. Accepted only when busy=0.
- tx_data  input  DW  word to write. Sampled in the cycle start is accepted.
- busy  output  1  high from the cycle after acceptance until the inter-frame gap ends.
- done  output  1  one-cycle pulse when the frame completes. rx_data is valid from this cycle on.
- rx_data  output  DW  previous target contents, captured MSB-first from spi_miso.
- spi_clk  output  1  SPI clock. Idles low.
- spi_csn  output  1  chip select, active low. Idles high.
- spi_mosi  output  1  serial data to the target.
- spi_miso  input  1  serial data from the target.

Behaviour:
- All outputs are registered.
- Reset values: busy=0, done=0, rx_data=0, spi_clk=0, spi_csn=1, spi_mosi=0. The FSM returns to IDLE.
- FSM states: IDLE, LEAD, HIGH, LOW, TRAIL, GAP.
- A half-period counter counts 0..CLK_DIV-1. A bit counter counts 0..DW-1.
- IDLE:
  - If start=1, at edge T0: latch tx_data into the tx shift register and go to LEAD.
  - From T0+1: spi_csn=0, spi_mosi=tx_data[DW-1], busy=1.
  - A start arriving while busy=1 is ignored, with no queuing.
- LEAD: spi_clk=0 for CLK_DIV cycles, then go to HIGH.
- HIGH:
  - On the entry edge: spi_clk goes to 1 and rx shifts in spi_miso, rx <= {rx[DW-2:0], spi_miso}.
  - spi_miso is sampled as it was during the preceding low phase, which has been stable since the target's previous rising edge.
  - Hold CLK_DIV cycles. Then go to LOW if bits sent < DW, otherwise go to TRAIL.
- LOW:
  - On the entry edge: spi_clk=0 and spi_mosi takes the next lower tx bit.
  - Hold CLK_DIV cycles, then go to HIGH.
- Rising edge i (i=0..DW-1) occurs at T0+1+CLK_DIV*(2i+1). spi_mosi is stable across each rising edge.
- TRAIL:
  - spi_clk=0 and spi_csn=0 for CLK_DIV cycles.
  - Then spi_csn=1 and spi_mosi=0, at T0+1+CLK_DIV*(2*DW+1).
  - done=1 for that single cycle and rx_data is updated; it holds until the next done or reset.
- GAP:
  - spi_csn=1 for CLK_DIV cycles. busy falls at T0+1+CLK_DIV*(2*DW+2).
  - start is accepted again in the cycle after busy=0 is first seen.
- Frame guarantees:
  - Exactly DW rising edges of spi_clk per frame.
  - No spi_clk edge while spi_csn=1.
  - spi_csn never pulses high mid-frame.
- Reset mid-frame (rst=1 at any edge):
  - Next cycle: spi_csn=1, spi_clk=0, busy=0.
  - No done pulse, and rx_data is cleared to 0.
  - The target keeps whatever partial shift occurred; this is the caller's concern.
- start and rst asserted together: rst wins and the start is discarded.
- Back-to-back operation: start held high continuously yields one frame per 1+CLK_DIV*(2*DW+2) cycles.
- rx_data semantics: bit DW-1 is the target MSB before the frame, down to bit 0 = target LSB before the frame.

Test Plan:
- Reset, then idle 20 cycles -> spi_csn=1, spi_clk=0, busy=0, done=0, rx_data=0, with no spi_clk toggles.
- Bench slave model reset to its default word W0; start with tx_data=42'h2AA_AAAA_AAA5 -> exactly 42 spi_clk rises, done at T0+1+2*85=T0+171, slave holds 42'h2AA_AAAA_AAA5, rx_data=W0.
- Second frame with tx_data=42'h155_5555_555A -> rx_data=42'h2AA_AAAA_AAA5, and slave holds the new word.
- start pulsed while busy at cycles T0+5 and T0+100 -> ignored: a single frame with a single done, and tx_data changes during the frame are not transmitted.
- rst asserted at T0+60 -> spi_csn=1 and busy=0 next cycle, no done, rx_data=0; a fresh start afterwards completes normally.
- CLK_DIV=4, tx_data=42'h3FF_FFFF_FFFF -> spi_clk half-period is 4 cycles, 42 rises, done at T0+1+4*85=T0+341, busy low at T0+345.

Source files
------------

// File: rtl/spi_config_master.sv
// rtl/spi_config_master.sv - SPI mode-0 initiator that loads one DW-bit config word and reads back the old one
module spi_config_master #(
    parameter int DW      = 42,
    parameter int CLK_DIV = 2,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] tx_data,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rx_data,
    output logic          spi_clk,
    output logic          spi_csn,
    output logic          spi_mosi,
    input  logic          spi_miso
);

    localparam int BW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_HIGH,
        S_LOW,
        S_TRAIL,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [DW-1:0] tx_q, tx_d;
    logic [DW-1:0] rx_sh_q, rx_sh_d;
    logic [DW-1:0] rx_data_q, rx_data_d;
    logic          spi_clk_q, spi_clk_d;
    logic          csn_q, csn_d;
    logic          mosi_q, mosi_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic hc_last;
    logic last_bit;

    assign hc_last  = (hcnt_q == CW'(CLK_DIV - 1));
    assign last_bit = (bcnt_q == BW'(DW - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            hcnt_q    <= '0;
            bcnt_q    <= '0;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            spi_clk_q <= 1'b0;
            csn_q     <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            bcnt_q    <= bcnt_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            spi_clk_q <= spi_clk_d;
            csn_q     <= csn_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Every non-idle state lasts exactly CLK_DIV cycles; the half-period counter restarts on each transition.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q + CW'(1);
        bcnt_d  = bcnt_q;
        case (state_q)
            S_IDLE: begin
                hcnt_d = '0;
                bcnt_d = '0;
                if (start) begin
                    state_d = S_LEAD;
                end
            end
            S_LEAD: begin
                if (hc_last) begin
                    state_d = S_HIGH;
                    hcnt_d  = '0;
                end
            end
            S_HIGH: begin
                if (hc_last) begin
                    hcnt_d = '0;
                    if (last_bit) begin
                        state_d = S_TRAIL;
                    end else begin
                        state_d = S_LOW;
                        bcnt_d  = bcnt_q + BW'(1);
                    end
                end
            end
            S_LOW: begin
                if (hc_last) begin
                    state_d = S_HIGH;
                    hcnt_d  = '0;
                end
            end
            S_TRAIL: begin
                if (hc_last) begin
                    state_d = S_GAP;
                    hcnt_d  = '0;
                end
            end
            S_GAP: begin
                if (hc_last) begin
                    state_d = S_IDLE;
                    hcnt_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                hcnt_d  = '0;
            end
        endcase
    end

    // Next values of the registered outputs; spi_miso is sampled on the same edge that raises spi_clk.
    always_comb begin
        spi_clk_d = spi_clk_q;
        csn_d     = csn_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tx_d      = tx_data;
                    csn_d     = 1'b0;
                    mosi_d    = tx_data[DW-1];
                    busy_d    = 1'b1;
                    spi_clk_d = 1'b0;
                end
            end
            S_LEAD, S_LOW: begin
                if (hc_last) begin
                    spi_clk_d = 1'b1;
                    rx_sh_d   = {rx_sh_q[DW-2:0], spi_miso};
                end
            end
            S_HIGH: begin
                if (hc_last) begin
                    spi_clk_d = 1'b0;
                    if (!last_bit) begin
                        tx_d   = {tx_q[DW-2:0], tx_q[DW-1]};
                        mosi_d = tx_q[DW-2];
                    end
                end
            end
            S_TRAIL: begin
                if (hc_last) begin
                    csn_d     = 1'b1;
                    mosi_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_sh_q;
                end
            end
            S_GAP: begin
                if (hc_last) begin
                    busy_d = 1'b0;
                end
            end
            default: begin
                spi_clk_d = 1'b0;
                csn_d     = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rx_data  = rx_data_q;
    assign spi_clk  = spi_clk_q;
    assign spi_csn  = csn_q;
    assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_config_master.sv
// tb/tb_spi_config_master.sv - directed bench for spi_config_master with a shift-register target model
module tb_spi_config_master;

    localparam int DW = 42;
    localparam logic [DW-1:0] W0  = 42'h0C3_5A5A_F00F;
    localparam logic [DW-1:0] D1  = 42'h2AA_AAAA_AAA5;
    localparam logic [DW-1:0] D2  = 42'h155_5555_555A;
    localparam logic [DW-1:0] D3  = 42'h0F0_F0F0_F0F0;
    localparam logic [DW-1:0] D4  = 42'h3C3_C3C3_C3C3;
    localparam logic [DW-1:0] D5  = 42'h012_3456_789A;
    localparam logic [DW-1:0] ONE = 42'h3FF_FFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: CLK_DIV=2
    logic          rst_a = 1'b1, start_a = 1'b0;
    logic [DW-1:0] tx_a = '0;
    logic          busy_a, done_a, spi_clk_a, spi_csn_a, spi_mosi_a, spi_miso_a;
    logic [DW-1:0] rx_a;

    // Instance B: CLK_DIV=4
    logic          rst_b = 1'b1, start_b = 1'b0;
    logic [DW-1:0] tx_b = '0;
    logic          busy_b, done_b, spi_clk_b, spi_csn_b, spi_mosi_b, spi_miso_b;
    logic [DW-1:0] rx_b;

    spi_config_master #(.DW(DW), .CLK_DIV(2), .CW(8)) u_dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .tx_data(tx_a),
        .busy(busy_a), .done(done_a), .rx_data(rx_a),
        .spi_clk(spi_clk_a), .spi_csn(spi_csn_a), .spi_mosi(spi_mosi_a), .spi_miso(spi_miso_a)
    );

    spi_config_master #(.DW(DW), .CLK_DIV(4), .CW(8)) u_dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .tx_data(tx_b),
        .busy(busy_b), .done(done_b), .rx_data(rx_b),
        .spi_clk(spi_clk_b), .spi_csn(spi_csn_b), .spi_mosi(spi_mosi_b), .spi_miso(spi_miso_b)
    );

    // Target shift registers: shift on each observed spi_clk rise while selected
    logic [DW-1:0] sreg_a, sreg_b;
    logic [DW-1:0] init_a = '0, init_b = '0;
    logic          load_a = 1'b0, load_b = 1'b0, clr_a = 1'b0, clr_b = 1'b0;
    logic          sck_d_a = 1'b0, sck_d_b = 1'b0;
    int            rises_a = 0, rises_b = 0, bad_a = 0, bad_b = 0;

    always @(posedge clk) begin
        sck_d_a <= spi_clk_a;
        if (load_a) sreg_a <= init_a;
        else if (spi_clk_a && !sck_d_a && !spi_csn_a) sreg_a <= {sreg_a[DW-2:0], spi_mosi_a};
        if (clr_a) begin
            rises_a <= 0;
            bad_a   <= 0;
        end else if (spi_clk_a && !sck_d_a) begin
            rises_a <= rises_a + 1;
            if (spi_csn_a) bad_a <= bad_a + 1;
        end
    end

    always @(posedge clk) begin
        sck_d_b <= spi_clk_b;
        if (load_b) sreg_b <= init_b;
        else if (spi_clk_b && !sck_d_b && !spi_csn_b) sreg_b <= {sreg_b[DW-2:0], spi_mosi_b};
        if (clr_b) begin
            rises_b <= 0;
            bad_b   <= 0;
        end else if (spi_clk_b && !sck_d_b) begin
            rises_b <= rises_b + 1;
            if (spi_csn_b) bad_b <= bad_b + 1;
        end
    end

    assign spi_miso_a = sreg_a[DW-1];
    assign spi_miso_b = sreg_b[DW-1];

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic prep_a(input logic [DW-1:0] w);
        @(negedge clk);
        init_a = w;
        load_a = 1'b1;
        clr_a  = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        clr_a  = 1'b0;
    endtask

    // Runs one frame on A; n counts cycles after the accepting edge (n=1 is the first busy cycle)
    task automatic frame_a(input logic [DW-1:0] data, input int p1, input int p2, input int rst_at,
                           output int done_at, output int blow_at, output int ndone);
        done_at = -1;
        blow_at = -1;
        ndone   = 0;
        @(negedge clk);
        tx_a    = data;
        start_a = 1'b1;
        for (int n = 1; n <= 1500; n++) begin
            @(negedge clk);
            start_a = 1'b0;
            rst_a   = 1'b0;
            if (n == p1 || n == p2) begin
                start_a = 1'b1;
                tx_a    = ~data;
            end
            if (n == rst_at) rst_a = 1'b1;
            if (done_a) begin
                ndone++;
                if (done_at < 0) done_at = n;
            end
            if (!busy_a) begin
                blow_at = n;
                break;
            end
        end
        start_a = 1'b0;
        rst_a   = 1'b0;
        if (blow_at < 0) check("frame_a_timeout", 64'd1, 64'd0);
    endtask

    int done_at, blow_at, ndone;
    int d1, d2, hi_run, first_run;

    initial begin
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_csn",   64'(spi_csn_a), 64'd1);
        check("idle_sclk",  64'(spi_clk_a), 64'd0);
        check("idle_busy",  64'(busy_a),    64'd0);
        check("idle_done",  64'(done_a),    64'd0);
        check("idle_rx",    64'(rx_a),      64'd0);
        check("idle_mosi",  64'(spi_mosi_a), 64'd0);
        check("idle_rises", 64'(rises_a),   64'd0);

        prep_a(W0);
        frame_a(D1, -1, -1, -1, done_at, blow_at, ndone);
        check("f1_done_at", 64'(done_at), 64'd171);
        check("f1_busy_lo", 64'(blow_at), 64'd173);
        check("f1_ndone",   64'(ndone),   64'd1);
        check("f1_rises",   64'(rises_a), 64'd42);
        check("f1_csn_hi_edges", 64'(bad_a), 64'd0);
        check("f1_slave",   64'(sreg_a),  64'(D1));
        check("f1_rx",      64'(rx_a),    64'(W0));

        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        frame_a(D2, -1, -1, -1, done_at, blow_at, ndone);
        check("f2_done_at", 64'(done_at), 64'd171);
        check("f2_rises",   64'(rises_a), 64'd42);
        check("f2_slave",   64'(sreg_a),  64'(D2));
        check("f2_rx",      64'(rx_a),    64'(D1));

        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        frame_a(D3, 5, 100, -1, done_at, blow_at, ndone);
        check("ign_ndone",   64'(ndone),   64'd1);
        check("ign_done_at", 64'(done_at), 64'd171);
        check("ign_rises",   64'(rises_a), 64'd42);
        check("ign_slave",   64'(sreg_a),  64'(D3));
        check("ign_rx",      64'(rx_a),    64'(D2));
        repeat (4) @(negedge clk);
        check("ign_no_refire", 64'(busy_a), 64'd0);

        frame_a(D4, -1, -1, 60, done_at, blow_at, ndone);
        check("rst_busy_lo_at", 64'(blow_at), 64'd61);
        check("rst_csn",   64'(spi_csn_a), 64'd1);
        check("rst_sclk",  64'(spi_clk_a), 64'd0);
        check("rst_ndone", 64'(ndone),     64'd0);
        check("rst_rx",    64'(rx_a),      64'd0);
        prep_a(W0);
        frame_a(D4, -1, -1, -1, done_at, blow_at, ndone);
        check("post_rst_done_at", 64'(done_at), 64'd171);
        check("post_rst_slave",   64'(sreg_a),  64'(D4));
        check("post_rst_rx",      64'(rx_a),    64'(W0));

        @(negedge clk);
        rst_a   = 1'b1;
        start_a = 1'b1;
        tx_a    = D5;
        @(negedge clk);
        rst_a   = 1'b0;
        start_a = 1'b0;
        check("rst_start_busy", 64'(busy_a),    64'd0);
        check("rst_start_csn",  64'(spi_csn_a), 64'd1);
        repeat (3) @(negedge clk);
        check("rst_start_idle", 64'(busy_a),    64'd0);

        // start held high: dones must be exactly one frame period apart
        d1 = -1;
        d2 = -1;
        @(negedge clk);
        tx_a    = D5;
        start_a = 1'b1;
        for (int n = 1; n <= 1200; n++) begin
            @(negedge clk);
            if (done_a) begin
                if (d1 < 0) d1 = n;
                else if (d2 < 0) d2 = n;
            end
            if (d2 >= 0) break;
        end
        start_a = 1'b0;
        check("b2b_first_done", 64'(d1), 64'd171);
        check("b2b_period",     64'(d2 - d1), 64'd173);
        for (int n = 0; n < 400 && busy_a; n++) @(negedge clk);
        check("b2b_settle", 64'(busy_a), 64'd0);

        // Instance B with CLK_DIV=4
        @(negedge clk);
        init_b = '0;
        load_b = 1'b1;
        clr_b  = 1'b1;
        @(negedge clk);
        load_b = 1'b0;
        clr_b  = 1'b0;
        @(negedge clk);
        tx_b    = ONE;
        start_b = 1'b1;
        done_at   = -1;
        blow_at   = -1;
        hi_run    = 0;
        first_run = -1;
        for (int n = 1; n <= 1500; n++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (spi_clk_b) hi_run++;
            else if (hi_run > 0) begin
                if (first_run < 0) first_run = hi_run;
                hi_run = 0;
            end
            if (done_b && done_at < 0) done_at = n;
            if (!busy_b) begin
                blow_at = n;
                break;
            end
        end
        check("b_half_period", 64'(first_run), 64'd4);
        check("b_rises",       64'(rises_b),   64'd42);
        check("b_csn_hi_edges", 64'(bad_b),    64'd0);
        check("b_done_at",     64'(done_at),   64'd341);
        check("b_busy_lo",     64'(blow_at),   64'd345);
        check("b_slave",       64'(sreg_b),    64'(ONE));
        check("b_rx",          64'(rx_b),      64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
